arbiter_control: RTL and testbench

Sequencing FSM for the cache-to-memory arbiter. It shares the single physical-memory port between the I-cache and the D-cache, grants one requester at a time, and drives `arbiter_address_MUX_sel` into `arbiter_datapath`. It forwards read/write strobes to memory and routes the memory response back to the granted cache only. D-cache has priority, with a bounded-starvation guarantee for the I-cache.

---
 rtl/arbiter_control.sv | 52 +++++
 tb/tb_arbiter_control.sv | 104 ++++++++++
 2 files changed

// File: rtl/arbiter_control.sv
// arbiter_control: D-priority I/D cache to memory arbiter FSM; ports: clk, rst(async low), i/d cache requests and resps, a_pmem strobes/resp, address mux select
package arbiteraddressmux;
    typedef enum logic {i_cache = 1'b0, d_cache = 1'b1} arbiteraddressmux_sel_t;
endpackage

module arbiter_control #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pmem_read,
    output logic i_pmem_resp,
    input  logic d_pmem_read,
    input  logic d_pmem_write,
    output logic d_pmem_resp,
    output logic a_pmem_read,
    output logic a_pmem_write,
    input  logic a_pmem_resp,
    output arbiteraddressmux::arbiteraddressmux_sel_t arbiter_address_MUX_sel
);
    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR, RECOVER} state_t;
    state_t state;
    logic [3:0] d_streak;
    logic d_req, d_grant;
    assign d_req = d_pmem_read | d_pmem_write;
    assign d_grant = d_req & (~i_pmem_read | (d_streak < 4'(MAX_D_STREAK)));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            d_streak <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_grant) begin
                        state <= d_pmem_write ? SERVE_D_WR : SERVE_D_RD;
                        d_streak <= i_pmem_read ? ((d_streak == 4'hF) ? d_streak : d_streak + 4'd1) : 4'd0;
                    end else if (i_pmem_read) begin
                        state <= SERVE_I;
                        d_streak <= 4'd0;
                    end
                end
                SERVE_I, SERVE_D_RD, SERVE_D_WR: state <= a_pmem_resp ? RECOVER : state;
                default: state <= IDLE;
            endcase
        end
    end
    assign a_pmem_read = (state == SERVE_I) | (state == SERVE_D_RD);
    assign a_pmem_write = state == SERVE_D_WR;
    assign i_pmem_resp = a_pmem_resp & (state == SERVE_I);
    assign d_pmem_resp = a_pmem_resp & ((state == SERVE_D_RD) | (state == SERVE_D_WR));
    assign arbiter_address_MUX_sel = ((state == SERVE_D_RD) | (state == SERVE_D_WR)) ? arbiteraddressmux::d_cache : arbiteraddressmux::i_cache;
endmodule

// File: tb/tb_arbiter_control.sv
// tb_arbiter_control: table-driven and scoreboarded checks of arbiter_control
module tb_arbiter_control;
    typedef struct packed {
        logic [3:0] in;
        logic [4:0] ex;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_pmem_read = 1'b0, d_pmem_read = 1'b0, d_pmem_write = 1'b0, a_pmem_resp = 1'b0;
    logic i_pmem_resp, d_pmem_resp, a_pmem_read, a_pmem_write;
    arbiteraddressmux::arbiteraddressmux_sel_t sel;
    int checks = 0;
    int failures = 0;
    int step_no = 0;
    logic [4:0] sb[$];
    vec_t tbl[$];
    arbiter_control #(.MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write), .d_pmem_resp(d_pmem_resp),
        .a_pmem_read(a_pmem_read), .a_pmem_write(a_pmem_write), .a_pmem_resp(a_pmem_resp),
        .arbiter_address_MUX_sel(sel)
    );
    always #5 clk = ~clk;
    task automatic compare(input string name);
        logic [4:0] act, exp;
        exp = sb.pop_front();
        act = {a_pmem_read, a_pmem_write, sel == arbiteraddressmux::d_cache, i_pmem_resp, d_pmem_resp};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got rd/wr/sel/iresp/dresp=%b expected %b", name, step_no, act, exp);
        end
    endtask
    task automatic drive(input logic [3:0] in, input logic [4:0] ex);
        {i_pmem_read, d_pmem_read, d_pmem_write, a_pmem_resp} = in;
        sb.push_back(ex);
    endtask
    task automatic step(input string name, input logic [3:0] in, input logic [4:0] ex);
        @(negedge clk);
        drive(in, ex);
        #1;
        step_no++;
        compare(name);
    endtask
    task automatic check_streak(input logic [3:0] exp);
        checks++;
        if (dut.d_streak !== exp) begin
            failures++;
            $display("FAIL d_streak: got %0d expected %0d", dut.d_streak, exp);
        end
    endtask
    initial begin
        tbl = '{
            {4'b0000, 5'b00000}, {4'b1000, 5'b00000}, {4'b1000, 5'b10000}, {4'b1000, 5'b10000},
            {4'b1001, 5'b10010}, {4'b0000, 5'b00000}, {4'b0000, 5'b00000},
            {4'b1100, 5'b00000}, {4'b1100, 5'b10100}, {4'b1101, 5'b10101}, {4'b1000, 5'b00000},
            {4'b1000, 5'b00000}, {4'b1001, 5'b10010}, {4'b0000, 5'b00000}, {4'b0000, 5'b00000},
            {4'b0110, 5'b00000}, {4'b0110, 5'b01100}, {4'b0000, 5'b01100}, {4'b0001, 5'b01101},
            {4'b0001, 5'b00000}, {4'b0000, 5'b00000},
            {4'b0001, 5'b00000}, {4'b0000, 5'b00000}
        };
        drive(4'b1101, 5'b00000);
        #1;
        compare("reset_state");
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0000, 5'b00000);
        #1;
        compare("reset_release");
        for (int i = 0; i < tbl.size(); i++) step("table", tbl[i].in, tbl[i].ex);
        for (int k = 0; k < 4; k++) begin
            step("streak_d_idle", 4'b1100, 5'b00000);
            step("streak_d_serve", 4'b1101, 5'b10101);
            step("streak_d_recover", 4'b1100, 5'b00000);
        end
        check_streak(4'd4);
        step("streak_i_idle", 4'b1100, 5'b00000);
        step("streak_i_serve", 4'b1101, 5'b10010);
        check_streak(4'd0);
        step("streak_i_recover", 4'b1100, 5'b00000);
        step("streak_d2_idle", 4'b1100, 5'b00000);
        step("streak_d2_serve", 4'b1101, 5'b10101);
        check_streak(4'd1);
        step("streak_d2_recover", 4'b0000, 5'b00000);
        step("abort_idle", 4'b0100, 5'b00000);
        step("abort_serve", 4'b0100, 5'b10100);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0101, 5'b00000);
        #1;
        compare("abort_reset");
        @(negedge clk);
        rst = 1'b1;
        drive(4'b0001, 5'b00000);
        #1;
        compare("abort_release");
        step("abort_after1", 4'b0001, 5'b00000);
        step("abort_after2", 4'b0000, 5'b00000);
        check_streak(4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
